// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, flag bit positions,
// the buffered command format and the opcode legality check.
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;

  // Bit positions inside the 4-bit flag vector {carry, zero, negative, overflow}
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       use_acc;
  } alu_cmd_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry synchronous FIFO of ALU commands with registered occupancy.
// The head entry is visible combinationally whenever the FIFO is non-empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  alu_cmd_t   push_data,
  input  logic       pop,
  output alu_cmd_t   head,
  output logic [AW:0] level,
  output logic       full,
  output logic       empty
);

  alu_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the combinational ALU: buffers commands, drives one
// per cycle into the ALU and registers its result/flags on a valid/ready port.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  input  logic [2:0]               in_op,
  input  logic                     in_use_acc,
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  output logic [2:0]               alu_op,
  input  logic [W-1:0]             alu_result,
  input  logic                     alu_carry,
  input  logic                     alu_zero,
  input  logic                     alu_negative,
  input  logic                     alu_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_result,
  output logic [3:0]               out_flags,
  output logic                     out_err,
  output logic [3:0]               sticky_flags,
  input  logic                     sticky_clr,
  output logic [$clog2(DEPTH):0]   level
);

  alu_cmd_t   push_data;
  alu_cmd_t   head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       issue;
  logic       head_legal;
  logic [W-1:0] acc;
  logic [W-1:0] cap_result;
  logic [3:0]   cap_flags;

  assign push_data = '{a: 4'(in_a), b: 4'(in_b), op: in_op, use_acc: in_use_acc};
  assign in_ready  = !fifo_full;
  assign issue     = !fifo_empty && (!out_valid || out_ready);

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid && in_ready),
    .push_data (push_data),
    .pop       (issue),
    .head      (head),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (!fifo_empty) begin
      alu_op = head.op;
      alu_b  = W'(head.b);
      alu_a  = head.use_acc ? acc : W'(head.a);
    end
  end

  // An illegal opcode leaves the ALU output undefined, so it is masked to zero
  // before it can reach the output register, the sticky flags or the accumulator.
  assign head_legal = is_legal_op(head.op);
  assign cap_result = head_legal ? alu_result : '0;
  assign cap_flags  = head_legal ? {alu_carry, alu_zero, alu_negative, alu_overflow} : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_flags    <= '0;
      out_err      <= 1'b0;
      acc          <= '0;
      sticky_flags <= '0;
    end else if (issue) begin
      out_valid    <= 1'b1;
      out_result   <= cap_result;
      out_flags    <= cap_flags;
      out_err      <= !head_legal;
      sticky_flags <= (sticky_clr ? 4'b0000 : sticky_flags) | cap_flags;
      if (head_legal) acc <= alu_result;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (sticky_clr) sticky_flags <= '0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural 4-bit ALU beside it;
// illegal opcodes make the ALU produce all-ones garbage that must never be captured.
module tb_alu_issue_stage;

  localparam int DEPTH = 4;
  localparam int W     = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [2:0]   in_op = '0;
  logic         in_use_acc = 1'b0;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_result;
  logic         alu_carry;
  logic         alu_zero;
  logic         alu_negative;
  logic         alu_overflow;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic [3:0]   out_flags;
  logic         out_err;
  logic [3:0]   sticky_flags;
  logic         sticky_clr = 1'b0;
  logic [$clog2(DEPTH):0] level;

  int checkCount = 0;
  int errorCount = 0;
  int validSeen  = 0;

  logic [4:0]   sum;
  logic [W-1:0] res;

  always #5 clk = ~clk;

  alu_issue_stage #(.DEPTH(DEPTH), .W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_op        (in_op),
    .in_use_acc   (in_use_acc),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .alu_overflow (alu_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_err      (out_err),
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr),
    .level        (level)
  );

  // Behavioural ALU: SUB carry means borrow, shifts never set C or V.
  always_comb begin
    sum          = '0;
    res          = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      3'b000: begin
        sum          = {1'b0, alu_a} + {1'b0, alu_b};
        res          = sum[3:0];
        alu_carry    = sum[4];
        alu_overflow = (alu_a[3] == alu_b[3]) && (res[3] != alu_a[3]);
      end
      3'b001: begin
        res          = alu_a - alu_b;
        alu_carry    = (alu_a < alu_b);
        alu_overflow = (alu_a[3] != alu_b[3]) && (res[3] != alu_a[3]);
      end
      3'b010:  res = alu_a & alu_b;
      3'b011:  res = alu_a | alu_b;
      3'b100:  res = alu_a << alu_b[1:0];
      3'b101:  res = alu_a >> alu_b[1:0];
      default: begin
        res          = 4'hF;
        alu_carry    = 1'b1;
        alu_overflow = 1'b1;
      end
    endcase
    alu_result   = res;
    alu_zero     = (alu_op > 3'b101) ? 1'b1 : (res == '0);
    alu_negative = (alu_op > 3'b101) ? 1'b1 : res[3];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offers one command for exactly one cycle.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic [2:0] op, input logic use_acc);
    in_valid   = 1'b1;
    in_a       = a;
    in_b       = b;
    in_op      = op;
    in_use_acc = use_acc;
    tick();
    in_valid   = 1'b0;
  endtask

  initial begin
    #12;
    checkOutput("reset in_ready",   32'(in_ready), 1);
    checkOutput("reset out_valid",  32'(out_valid), 0);
    checkOutput("reset out_err",    32'(out_err), 0);
    checkOutput("reset out_result", 32'(out_result), 0);
    checkOutput("reset out_flags",  32'(out_flags), 0);
    checkOutput("reset sticky",     32'(sticky_flags), 0);
    checkOutput("reset level",      32'(level), 0);
    checkOutput("reset alu_drive",  32'({alu_a, alu_b, alu_op}), 0);
    #5 rst_n = 1'b1;
    tick();

    // Single ADD 7+9
    applyStimulus(4'd7, 4'd9, 3'b000, 1'b0);
    checkOutput("add level",     32'(level), 1);
    checkOutput("add alu_a",     32'(alu_a), 7);
    checkOutput("add no_bypass", 32'(out_valid), 0);
    tick();
    checkOutput("add valid",  32'(out_valid), 1);
    checkOutput("add result", 32'(out_result), 0);
    checkOutput("add flags",  32'(out_flags), 4'b1100);
    checkOutput("add sticky", 32'(sticky_flags), 4'b1100);
    tick();
    checkOutput("add drained", 32'(out_valid), 0);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    checkOutput("sticky cleared", 32'(sticky_flags), 0);

    // Accumulator chain: 3+2 then acc<<1
    applyStimulus(4'd3, 4'd2, 3'b000, 1'b0);
    applyStimulus(4'd0, 4'd1, 3'b100, 1'b1);
    checkOutput("chain r1", 32'(out_result), 5);
    checkOutput("chain f1", 32'(out_flags), 4'b0000);
    tick();
    checkOutput("chain r2",     32'(out_result), 10);
    checkOutput("chain f2",     32'(out_flags), 4'b0010);
    checkOutput("chain sticky", 32'(sticky_flags), 4'b0010);
    tick();

    // Full FIFO under back-pressure: commands i+2 for i=1..6
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid   = 1'b1;
      in_a       = 4'(i);
      in_b       = 4'd2;
      in_op      = 3'b000;
      in_use_acc = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    checkOutput("full level",    32'(level), 4);
    checkOutput("full in_ready", 32'(in_ready), 0);
    checkOutput("full valid",    32'(out_valid), 1);
    checkOutput("full held",     32'(out_result), 3);
    tick();
    checkOutput("full stable", 32'(out_result), 3);
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      tick();
      checkOutput("drain valid",  32'(out_valid), 1);
      checkOutput("drain result", 32'(out_result), 32'(k + 2));
    end
    tick();
    checkOutput("drain done",  32'(out_valid), 0);
    checkOutput("drain level", 32'(level), 0);

    // Illegal opcode followed by acc+1 (acc still 7)
    applyStimulus(4'd5, 4'd5, 3'b110, 1'b0);
    applyStimulus(4'd0, 4'd1, 3'b000, 1'b1);
    checkOutput("illegal err",    32'(out_err), 1);
    checkOutput("illegal result", 32'(out_result), 0);
    checkOutput("illegal flags",  32'(out_flags), 0);
    checkOutput("illegal sticky", 32'(sticky_flags), 4'b0010);
    tick();
    checkOutput("post_illegal err",    32'(out_err), 0);
    checkOutput("post_illegal result", 32'(out_result), 8);
    checkOutput("post_illegal flags",  32'(out_flags), 4'b0011);
    tick();

    // Sticky clear colliding with an issuing SUB 8-1
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    applyStimulus(4'd5, 4'd1, 3'b100, 1'b0);
    tick();
    checkOutput("pre_collide sticky", 32'(sticky_flags), 4'b0010);
    applyStimulus(4'd8, 4'd1, 3'b001, 1'b0);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    checkOutput("collide result", 32'(out_result), 7);
    checkOutput("collide flags",  32'(out_flags), 4'b0001);
    checkOutput("collide sticky", 32'(sticky_flags), 4'b0001);
    tick();

    // Reset mid-stream: one result pending plus three buffered commands
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_a     = 4'(i + 1);
      in_b     = 4'd1;
      in_op    = 3'b011;
      tick();
    end
    in_valid = 1'b0;
    checkOutput("midrst level", 32'(level), 3);
    checkOutput("midrst valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async valid",    32'(out_valid), 0);
    checkOutput("async level",    32'(level), 0);
    checkOutput("async in_ready", 32'(in_ready), 1);
    checkOutput("async result",   32'(out_result), 0);
    checkOutput("async sticky",   32'(sticky_flags), 0);
    checkOutput("async alu",      32'({alu_a, alu_b, alu_op}), 0);
    tick();
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid) validSeen++;
    end
    checkOutput("post_reset valid_count", 32'(validSeen), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
